// File: rtl/store_unit.sv
// Store buffer between the M stage and data memory: aligns byte/half/word stores,
// queues them in a small FIFO and drains them one write request at a time.
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  Mem_type,
    output logic        st_ready,
    output logic        AdES,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [29:0]        r_addr_mem [DEPTH];
    logic [3:0]         r_be_mem   [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];

    logic [3:0]         w_be;
    logic [31:0]        w_data;
    logic               w_misalign;
    logic               w_reserved;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_hit;
    logic               w_ld_unused;

    // Lane alignment and misalignment detection.
    always_comb begin
        w_be       = 4'b0000;
        w_data     = st_data;
        w_misalign = 1'b0;
        w_reserved = 1'b0;
        case (Mem_type)
            2'b00: begin
                w_be       = 4'b1111;
                w_data     = st_data;
                w_misalign = (st_addr[1:0] != 2'b00);
            end
            2'b01: begin
                w_be       = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data     = {st_data[15:0], st_data[15:0]};
                w_misalign = st_addr[0];
            end
            2'b10: begin
                w_be       = 4'b0001 << st_addr[1:0];
                w_data     = {4{st_data[7:0]}};
            end
            default: begin
                w_reserved = 1'b1;
            end
        endcase
    end

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign st_ready = !w_full;
    assign AdES     = reset && st_valid && w_misalign;
    assign w_push   = st_valid && st_ready && !w_reserved && !w_misalign;
    assign w_pop    = bus_req && bus_ack;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= st_addr[31:2];
            r_be_mem[r_wr_ptr]   <= w_be;
            r_data_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus_req      = 1'b0;
        empty        = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_push) w_state_next = ISSUE;
            end
            ISSUE: begin
                bus_req = 1'b1;
                empty   = 1'b0;
                // Last entry leaving with nothing arriving behind it.
                if (w_pop && !w_push && (r_count == CNT_W'(1))) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus_addr  = {r_addr_mem[r_rd_ptr], 2'b00};
    assign bus_wdata = r_data_mem[r_rd_ptr];
    assign bus_be    = r_be_mem[r_rd_ptr];

    // An entry is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] w_off;
        assign w_off     = PTR_W'(gi) - r_rd_ptr;
        assign w_hit[gi] = ({1'b0, w_off} < r_count) && (r_addr_mem[gi] == ld_addr[31:2]);
    end

    assign ld_hazard   = reset && ld_check && (|w_hit);
    assign w_ld_unused = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: table of alignment vectors plus hand-written
// sequences for stalls, back-pressure, load hazards and mid-transaction reset.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  Mem_type;
    logic        st_ready;
    logic        AdES;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    store_unit #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .Mem_type  (Mem_type),
        .st_ready  (st_ready),
        .AdES      (AdES),
        .ld_check  (ld_check),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mtype;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_ades;
        logic        exp_acc;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [1:0] mt, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        Mem_type = mt;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"sb_1003",   2'b10, 32'h0000_1003, 32'h1234_56AB, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
        vecs[1]  = '{"sh_2002",   2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF};
        vecs[2]  = '{"sh_2000",   2'b01, 32'h0000_2000, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_2000, 4'b0011, 32'h1234_1234};
        vecs[3]  = '{"sw_4008",   2'b00, 32'h0000_4008, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_4008, 4'b1111, 32'hCAFE_F00D};
        vecs[4]  = '{"sb_5000",   2'b10, 32'h0000_5000, 32'h0000_005A, 1'b0, 1'b1, 32'h0000_5000, 4'b0001, 32'h5A5A_5A5A};
        vecs[5]  = '{"sb_5001",   2'b10, 32'h0000_5001, 32'hFFFF_FF77, 1'b0, 1'b1, 32'h0000_5000, 4'b0010, 32'h7777_7777};
        vecs[6]  = '{"sw_1001",   2'b00, 32'h0000_1001, 32'h1111_1111, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
        vecs[7]  = '{"sh_2001",   2'b01, 32'h0000_2001, 32'h2222_2222, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
        vecs[8]  = '{"sw_1002",   2'b00, 32'h0000_1002, 32'h3333_3333, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};
        vecs[9]  = '{"rsv_1000",  2'b11, 32'h0000_1000, 32'h4444_4444, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        vecs[10] = '{"sh_2003",   2'b01, 32'h0000_2003, 32'h5555_5555, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0};

        // Reset state, with a misaligned store and a load presented during reset.
        reset    = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'h0000_1001;
        st_data  = 32'h0;
        Mem_type = 2'b00;
        ld_check = 1'b1;
        ld_addr  = 32'h0000_1000;
        bus_ack  = 1'b1;
        #2;
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_ades", {31'b0, AdES}, 32'd0);
        chk("rst_ld_hazard", {31'b0, ld_hazard}, 32'd0);
        st_valid = 1'b0;
        ld_check = 1'b0;
        bus_ack  = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            st_valid = 1'b1;
            Mem_type = vecs[i].mtype;
            st_addr  = vecs[i].addr;
            st_data  = vecs[i].data;
            #1;
            chk({vecs[i].name, "_ades"}, {31'b0, AdES}, {31'b0, vecs[i].exp_ades});
            tick();
            st_valid = 1'b0;
            #1;
            chk({vecs[i].name, "_bus_req"}, {31'b0, bus_req}, {31'b0, vecs[i].exp_acc});
            chk({vecs[i].name, "_empty"}, {31'b0, empty}, {31'b0, !vecs[i].exp_acc});
            if (vecs[i].exp_acc) begin
                chk({vecs[i].name, "_addr"}, bus_addr, vecs[i].exp_baddr);
                chk({vecs[i].name, "_be"}, {28'b0, bus_be}, {28'b0, vecs[i].exp_be});
                chk({vecs[i].name, "_wdata"}, bus_wdata, vecs[i].exp_wdata);
                bus_ack = 1'b1;
                tick();
                bus_ack = 1'b0;
                #1;
                chk({vecs[i].name, "_drained"}, {31'b0, empty}, 32'd1);
            end
            $display("vector %0d %s done", i, vecs[i].name);
        end

        // Half store held without acknowledge: outputs must not move.
        push_store(2'b01, 32'h0000_2002, 32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            chk("stall_req", {31'b0, bus_req}, 32'd1);
            chk("stall_addr", bus_addr, 32'h0000_2000);
            chk("stall_be", {28'b0, bus_be}, 32'h0000_000C);
            chk("stall_wdata", bus_wdata, 32'hBEEF_BEEF);
            tick();
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("stall_drain_empty", {31'b0, empty}, 32'd1);
        $display("stall sequence done");

        // Three back-to-back word stores into a two-entry buffer.
        st_valid = 1'b1;
        Mem_type = 2'b00;
        st_addr  = 32'h0000_0100;
        st_data  = 32'hA000_0001;
        tick();
        chk("bp_ready_after1", {31'b0, st_ready}, 32'd1);
        st_addr = 32'h0000_0104;
        st_data = 32'hA000_0002;
        tick();
        chk("bp_ready_after2", {31'b0, st_ready}, 32'd0);
        st_addr = 32'h0000_0108;
        st_data = 32'hA000_0003;
        tick();
        chk("bp_third_refused", {31'b0, st_ready}, 32'd0);
        chk("bp_head0", bus_addr, 32'h0000_0100);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("bp_ready_after_ack", {31'b0, st_ready}, 32'd1);
        chk("bp_head1", bus_addr, 32'h0000_0104);
        tick();
        st_valid = 1'b0;
        chk("bp_full_again", {31'b0, st_ready}, 32'd0);
        chk("bp_head1_hold", bus_addr, 32'h0000_0104);
        bus_ack = 1'b1;
        tick();
        chk("bp_head2", bus_addr, 32'h0000_0108);
        chk("bp_head2_data", bus_wdata, 32'hA000_0003);
        tick();
        bus_ack = 1'b0;
        chk("bp_empty", {31'b0, empty}, 32'd1);
        $display("back-pressure sequence done");

        // Simultaneous push and pop.
        push_store(2'b00, 32'h0000_6000, 32'h6000_0000);
        st_valid = 1'b1;
        st_addr  = 32'h0000_6004;
        st_data  = 32'h6000_0004;
        bus_ack  = 1'b1;
        tick();
        st_valid = 1'b0;
        bus_ack  = 1'b0;
        chk("pp_head", bus_addr, 32'h0000_6004);
        chk("pp_ready", {31'b0, st_ready}, 32'd1);
        chk("pp_req", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("pp_empty", {31'b0, empty}, 32'd1);
        $display("push-pop sequence done");

        // Load hazard against a pending word store.
        push_store(2'b00, 32'h0000_3004, 32'h3000_0004);
        ld_check = 1'b1;
        ld_addr  = 32'h0000_3006;
        #1;
        chk("hz_same_word", {31'b0, ld_hazard}, 32'd1);
        ld_addr = 32'h0000_3008;
        #1;
        chk("hz_next_word", {31'b0, ld_hazard}, 32'd0);
        ld_check = 1'b0;
        ld_addr  = 32'h0000_3004;
        #1;
        chk("hz_no_check", {31'b0, ld_hazard}, 32'd0);
        ld_check = 1'b1;
        bus_ack  = 1'b1;
        #1;
        chk("hz_during_ack", {31'b0, ld_hazard}, 32'd1);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("hz_after_pop", {31'b0, ld_hazard}, 32'd0);
        ld_check = 1'b0;
        $display("hazard sequence done");

        // Reset in the middle of a pending transaction with two entries.
        push_store(2'b00, 32'h0000_7000, 32'h7000_0000);
        push_store(2'b00, 32'h0000_7004, 32'h7000_0004);
        chk("mr_pre_req", {31'b0, bus_req}, 32'd1);
        chk("mr_pre_full", {31'b0, st_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mr_req", {31'b0, bus_req}, 32'd0);
        chk("mr_empty", {31'b0, empty}, 32'd1);
        chk("mr_ready", {31'b0, st_ready}, 32'd1);
        tick();
        #2;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mr_post_req", {31'b0, bus_req}, 32'd0);
            chk("mr_post_empty", {31'b0, empty}, 32'd1);
        end
        $display("mid-transaction reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, store-buffer entry count, power of two and at least 2.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port st_valid  input  1  store request from M stage.
REQ-005 The module SHALL have port st_addr  input  32  byte address (ALU result).
REQ-006 The module SHALL have port st_data  input  32  raw RT value.
REQ-007 The module SHALL have port Mem_type  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-008 The module SHALL have port st_ready  output  1  buffer not full.
REQ-009 The module SHALL have port AdES  output  1  misaligned-store exception.
REQ-010 The module SHALL have port ld_check  input  1  M-stage load present.
REQ-011 The module SHALL have port ld_addr  input  32  load byte address.
REQ-012 The module SHALL have port ld_hazard  output  1  load hits a pending store word.
REQ-013 The module SHALL have port bus_req  output  1  write request to data memory.
REQ-014 The module SHALL have port bus_addr  output  32  word-aligned address, with [1:0]=00.
REQ-015 The module SHALL have port bus_wdata  output  32  lane-aligned write data.
REQ-016 The module SHALL have port bus_be  output  4  byte enables, where bit i maps to byte lane i.
REQ-017 The module SHALL have port bus_ack  input  1  single-cycle write completion.
REQ-018 The module SHALL have port empty  output  1  no pending stores.

Function
REQ-019 The module SHALL align a word store to be=1111 with data=st_data.
REQ-020 The module SHALL align a half store to be=0011 when addr[1]=0 and be=1100 when addr[1]=1, with data={st_data[15:0],st_data[15:0]}.
REQ-021 The module SHALL align a byte store to be=0001<<addr[1:0], with data equal to st_data[7:0] replicated four times.
REQ-022 The module SHALL treat a word store with addr[1:0]!=00, or a half store with addr[0]!=0, as misaligned.
REQ-023 For a misaligned store, the module SHALL drive AdES combinationally in the same cycle while st_valid is high, and SHALL NOT create an entry.
REQ-024 For Mem_type=11, the module SHALL create no entry and drive no AdES.
REQ-025 The module SHALL accept a store when st_valid=1, st_ready=1, Mem_type!=11 and the access is aligned.
REQ-026 An accepted store SHALL write {addr[31:2], be, data} into the FIFO tail on the clock edge.
REQ-027 The module SHALL drive st_ready = !full, independent of bus_ack in the same cycle; no push is allowed when full.
REQ-028 The module SHALL implement an FSM with two states: IDLE (count=0) and ISSUE (count>0).
REQ-029 In IDLE, the module SHALL drive bus_req=0 and empty=1.
REQ-030 In ISSUE, the module SHALL drive bus_req=1, with bus_addr/bus_wdata/bus_be taken from the FIFO head.
REQ-031 A push into an empty buffer SHALL raise bus_req on the following cycle (1-cycle latency).
REQ-032 The module SHALL hold bus_req, bus_addr, bus_wdata and bus_be stable until bus_ack=1 is sampled.
REQ-033 On bus_ack with bus_req=1, the module SHALL pop the head at the clock edge.
REQ-034 After a pop, if count stays above 0, the module SHALL keep bus_req high and present the next head on the next cycle.
REQ-035 After a pop that empties the buffer, the module SHALL return to IDLE.
REQ-036 The module SHALL ignore bus_ack while bus_req=0.
REQ-037 On a simultaneous push and pop, the module SHALL keep count unchanged and advance both pointers.
REQ-038 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-039 The module SHALL drive ld_hazard = ld_check AND (any valid entry with addr[31:2]==ld_addr[31:2]), combinationally.
REQ-040 ld_hazard SHALL cover the head entry while it is being acknowledged in the same cycle.

Reset
REQ-041 While reset=0, the module SHALL asynchronously clear count, pointers and FSM (to IDLE), and drive bus_req=0, empty=1 and st_ready=1.
REQ-042 While reset=0, the module SHALL drive AdES=0 and ld_hazard=0 regardless of inputs.
REQ-043 Reset asserted mid-transaction SHALL drop bus_req immediately and discard all pending entries; no retry SHALL occur after reset.

Verification
REQ-044 The bench SHALL cover: sb to 0x0000_1003 with st_data=0x1234_56AB -> next cycle bus_req=1, bus_addr=0x0000_1000, bus_be=1000, bus_wdata=0xABAB_ABAB.
REQ-045 The bench SHALL cover: sh to 0x0000_2002 with st_data=0xDEAD_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF; with bus_ack held 0 for 5 cycles, outputs stay stable.
REQ-046 The bench SHALL cover: sw to 0x0000_1001 -> AdES=1 in the same cycle, empty stays 1, bus_req stays 0.
REQ-047 The bench SHALL cover: three back-to-back sw with DEPTH=2 and bus_ack=0 -> st_ready=0 after the second push; the third store is refused until the first bus_ack.
REQ-048 The bench SHALL cover: a pending sw to 0x0000_3004 with ld_check=1 and ld_addr=0x0000_3006 -> ld_hazard=1; with ld_addr=0x0000_3008 -> ld_hazard=0.
REQ-049 The bench SHALL cover: reset=0 while bus_req=1 with 2 entries -> bus_req=0 and empty=1 without a clock edge; after release, no bus activity occurs.
